// File: rtl/hc_fifo_wr_arbiter_if.sv
// Bundle between NUM_REQ requesters, the round-robin enqueue arbiter and one hc_fifo write port.
// The arbiter takes the master modport; the requesters/FIFO side takes the slave modport.
interface hc_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_enq_data;
  logic                          fifo_enq_en;
  logic                          fifo_not_full;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  modport master (
    input  req_valid, req_data, req_last, fifo_not_full,
    output req_ready, fifo_enq_data, fifo_enq_en, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_not_full,
    input  req_ready, fifo_enq_data, fifo_enq_en, grant_valid, grant_id
  );
endinterface

// File: rtl/hc_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one hc_fifo enqueue port among NUM_REQ requesters,
// granting bursts of up to MAX_BURST beats with one idle cycle between grants.
module hc_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hc_fifo_wr_arbiter_if.master  bus
);
  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_id;
  logic [CNTW-1:0]   burst_cnt;
  logic              grant_valid;

  logic              found;
  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    scan_idx;
  logic              xfer;
  logic              burst_end;
  logic [NUM_REQ-1:0] ready;

  // Winner search starts at rr_ptr and wraps, so the first hit is the fairest choice.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign xfer      = (state == BURST) && bus.req_valid[grant_id] && bus.fifo_not_full;
  // A granted requester that drops valid forfeits the rest of its burst.
  assign burst_end = (state == BURST) &&
                     (!bus.req_valid[grant_id] ||
                      (xfer && (bus.req_last[grant_id] || burst_cnt == CNTW'(MAX_BURST - 1))));

  always_comb begin
    ready           = '0;
    ready[grant_id] = xfer;
  end

  assign bus.req_ready     = ready;
  assign bus.fifo_enq_en   = xfer;
  assign bus.fifo_enq_data = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_valid   = grant_valid;
  assign bus.grant_id      = grant_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= BURST;
            grant_id    <= winner;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            burst_cnt   <= '0;
            rr_ptr      <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
          end else if (xfer) begin
            burst_cnt   <= burst_cnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hc_fifo_wr_arbiter.sv
// Directed bench for hc_fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=512).
// Each requester offers beats mk(id, n) for n < nbeats[id], last on beat last_at[id].
module tb_hc_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 512;
  localparam int MB = 4;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  int   cnt[NR];
  int   nbeats[NR];
  int   last_at[NR];
  logic nf;

  logic [DW-1:0] o_data;
  logic [NR-1:0] o_rdy;
  logic          o_en;
  logic          o_gv;
  logic [1:0]    o_gid;

  hc_fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  hc_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int id, input int beat);
    logic [7:0]  idb;
    logic [23:0] bb;
    idb = id[7:0];
    bb  = beat[23:0];
    return {16{idb, bb}};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]           = (cnt[i] < nbeats[i]);
      bus.req_last[i]            = (cnt[i] == last_at[i]);
      bus.req_data[i*DW +: DW]   = mk(i, cnt[i]);
    end
    bus.fifo_not_full = nf;
  endtask

  // One clock: apply inputs at negedge, sample #1 later, let the edge pass,
  // then retire accepted beats in the requester sources.
  task automatic cycle();
    drive();
    #1;
    o_data = bus.fifo_enq_data;
    o_rdy  = bus.req_ready;
    o_en   = bus.fifo_enq_en;
    o_gv   = bus.grant_valid;
    o_gid  = bus.grant_id;
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (o_rdy[i]) cnt[i]++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nf = 1'b1;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0; nbeats[i] = 0; last_at[i] = -1;
    end
    drive();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    nf = 1'b1;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0; nbeats[i] = 1000; last_at[i] = -1;
    end
    drive();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.grant_valid, bus.fifo_enq_en, bus.req_ready, bus.grant_id} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got gv/en/rdy/gid=%b want 00000000",
               {bus.grant_valid, bus.fifo_enq_en, bus.req_ready, bus.grant_id});
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    do_reset();
    nbeats[0] = 3; last_at[0] = 2;
    cycle();
    checks++;
    if ({o_gv, o_en, o_rdy} !== 6'b0) begin
      errors++; $display("FAIL single_idle: got gv/en/rdy=%b want 000000", {o_gv, o_en, o_rdy});
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({o_gv, o_en, o_rdy, o_gid} !== {1'b1, 1'b1, 4'b0001, 2'd0}) begin
        errors++; $display("FAIL single_beat%0d_ctl: got %b want 11000100", k, {o_gv, o_en, o_rdy, o_gid});
      end
      checks++;
      if (o_data !== mk(0, k)) begin
        errors++; $display("FAIL single_beat%0d_data: got %h want %h", k, o_data, mk(0, k));
      end
    end
    cycle();
    checks++;
    if ({o_gv, o_en} !== 2'b00) begin
      errors++; $display("FAIL single_drop: got gv/en=%b want 00", {o_gv, o_en});
    end
    // rr_ptr is now 1: requesters 0 and 1 both pending must yield 1 first.
    nbeats[0] = 4; last_at[0] = 3;
    nbeats[1] = 1; last_at[1] = 0;
    cycle();
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++; $display("FAIL single_rr_ptr: got gv/gid/rdy=%b want 1010010", {o_gv, o_gid, o_rdy});
    end
  endtask

  task automatic test_all_continuous();
    do_reset();
    for (int i = 0; i < NR; i++) nbeats[i] = 1000;
    for (int b = 0; b < 5; b++) begin
      int g;
      int base;
      g = b % NR;
      base = (b / NR) * MB;
      cycle();
      checks++;
      if ({o_gv, o_en, o_rdy} !== 6'b0) begin
        errors++; $display("FAIL rr_bubble%0d: got gv/en/rdy=%b want 000000", b, {o_gv, o_en, o_rdy});
      end
      for (int k = 0; k < MB; k++) begin
        logic [3:0] er;
        er = 4'b0001 << g;
        cycle();
        checks++;
        if ({o_gv, o_en, o_gid, o_rdy} !== {1'b1, 1'b1, 2'(g), er}) begin
          errors++; $display("FAIL rr_burst%0d_beat%0d_ctl: got %b want %b", b, k,
                             {o_gv, o_en, o_gid, o_rdy}, {1'b1, 1'b1, 2'(g), er});
        end
        checks++;
        if (o_data !== mk(g, base + k)) begin
          errors++; $display("FAIL rr_burst%0d_beat%0d_data: got %h want %h", b, k, o_data, mk(g, base + k));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    nbeats[0] = 1000;
    cycle();
    cycle();
    cycle();
    checks++;
    if ({o_en, o_data} !== {1'b1, mk(0, 1)}) begin
      errors++; $display("FAIL stall_beat1: got en=%b data=%h want 1 %h", o_en, o_data, mk(0, 1));
    end
    nf = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cycle();
      checks++;
      if ({o_gv, o_gid, o_en, o_rdy} !== {1'b1, 2'd0, 1'b0, 4'b0000}) begin
        errors++; $display("FAIL stall_hold%0d: got gv/gid/en/rdy=%b want 10000000", s, {o_gv, o_gid, o_en, o_rdy});
      end
    end
    nf = 1'b1;
    for (int k = 2; k < 4; k++) begin
      cycle();
      checks++;
      if ({o_en, o_rdy, o_data} !== {1'b1, 4'b0001, mk(0, k)}) begin
        errors++; $display("FAIL stall_resume%0d: got en=%b rdy=%b data=%h want 1 0001 %h", k, o_en, o_rdy, o_data, mk(0, k));
      end
    end
    cycle();
    checks++;
    if ({o_gv, o_en} !== 2'b00) begin
      errors++; $display("FAIL stall_total4: got gv/en=%b want 00", {o_gv, o_en});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    nbeats[2] = 1; last_at[2] = 0;
    cycle();
    cycle();
    checks++;
    if ({o_gid, o_en} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL wrap_setup: got gid/en=%b want 101", {o_gid, o_en});
    end
    nbeats[1] = 1; last_at[1] = 0;
    nbeats[3] = 1; last_at[3] = 0;
    cycle();
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy, o_data} !== {1'b1, 2'd3, 4'b1000, mk(3, 0)}) begin
      errors++; $display("FAIL wrap_first3: got gv=%b gid=%0d rdy=%b want 1 3 1000", o_gv, o_gid, o_rdy);
    end
    cycle();
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy, o_data} !== {1'b1, 2'd1, 4'b0010, mk(1, 0)}) begin
      errors++; $display("FAIL wrap_then1: got gv=%b gid=%0d rdy=%b want 1 1 0010", o_gv, o_gid, o_rdy);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    nbeats[2] = 2;
    nbeats[3] = 1; last_at[3] = 0;
    cycle();
    cycle();
    nbeats[0] = 1; last_at[0] = 0;
    cycle();
    checks++;
    if ({o_gid, o_en, o_data} !== {2'd2, 1'b1, mk(2, 1)}) begin
      errors++; $display("FAIL abandon_beat1: got gid=%0d en=%b data=%h", o_gid, o_en, o_data);
    end
    cycle();
    checks++;
    if ({o_gv, o_en, o_rdy} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL abandon_noxfer: got gv/en/rdy=%b want 100000", {o_gv, o_en, o_rdy});
    end
    cycle();
    checks++;
    if (o_gv !== 1'b0) begin
      errors++; $display("FAIL abandon_bubble: got gv=%b want 0", o_gv);
    end
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy} !== {1'b1, 2'd3, 4'b1000}) begin
      errors++; $display("FAIL abandon_next3: got gv=%b gid=%0d rdy=%b want 1 3 1000", o_gv, o_gid, o_rdy);
    end
    cycle();
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++; $display("FAIL abandon_then0: got gv=%b gid=%0d rdy=%b want 1 0 0001", o_gv, o_gid, o_rdy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    nbeats[1] = 1000;
    cycle();
    cycle();
    cycle();
    checks++;
    if ({o_gid, o_en} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL midrst_setup: got gid/en=%b want 011", {o_gid, o_en});
    end
    nbeats[3] = 1000;
    drive();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant_valid, bus.req_ready, bus.fifo_enq_en, bus.grant_id} !== 8'b0) begin
      errors++; $display("FAIL midrst_immediate: got gv/rdy/en/gid=%b want 00000000",
                         {bus.grant_valid, bus.req_ready, bus.fifo_enq_en, bus.grant_id});
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    checks++;
    if ({o_gv, o_en} !== 2'b00) begin
      errors++; $display("FAIL midrst_idle: got gv/en=%b want 00", {o_gv, o_en});
    end
    cycle();
    checks++;
    if ({o_gv, o_gid, o_rdy} !== {1'b1, 2'd1, 4'b0010}) begin
      errors++; $display("FAIL midrst_grant1: got gv=%b gid=%0d rdy=%b want 1 1 0010", o_gv, o_gid, o_rdy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    nf = 1'b1;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.fifo_not_full = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_all_continuous();
    test_stall();
    test_wrap();
    test_abandon();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
